// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch pipeline bus: the instruction handshake from IF and the registered ID/EX bundle.
// The stage uses the slave modport. The upstream and downstream side uses the master modport.
interface operand_fetch_stage_if #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int IW = 16
);
    logic          In_valid;
    logic [IW-1:0] Instr;
    logic          Flush;
    logic          Stall;
    logic          Out_valid;
    logic [3:0]    Out_op;
    logic [AW-1:0] Out_rd;
    logic          Out_we;
    logic          Out_is_load;
    logic [DW-1:0] Out_a;
    logic [DW-1:0] Out_b;

    modport master (
        output In_valid, Instr, Flush,
        input  Stall, Out_valid, Out_op, Out_rd, Out_we, Out_is_load, Out_a, Out_b
    );

    modport slave (
        input  In_valid, Instr, Flush,
        output Stall, Out_valid, Out_op, Out_rd, Out_we, Out_is_load, Out_a, Out_b
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// ID/operand-fetch stage: decodes the instruction and forwards operands from EX/WB.
// It also stalls on load-use hazards and registers the ID/EX bundle.
module operand_fetch_stage #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int IW = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    operand_fetch_stage_if.slave  bus,
    output logic [AW-1:0]         Raddr_a,
    output logic [AW-1:0]         Raddr_b,
    input  logic [DW-1:0]         Rdata_a,
    input  logic [DW-1:0]         Rdata_b,
    input  logic                  Ex_we,
    input  logic [AW-1:0]         Ex_waddr,
    input  logic [DW-1:0]         Ex_result,
    input  logic                  Ex_is_load,
    input  logic                  Wb_we,
    input  logic [AW-1:0]         Wb_waddr,
    input  logic [DW-1:0]         Wb_data,
    output logic [7:0]            Stall_count
);
    logic [3:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [5:0]    imm6;
    logic [DW-1:0] imm;
    logic          uses_rb;
    logic          is_load;
    logic          we;
    logic          use_imm;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] opnd_b;
    logic          hazard;

    assign op      = bus.Instr[IW-1 -: 4];
    assign rd      = bus.Instr[11:9];
    assign ra      = bus.Instr[8:6];
    assign rb      = bus.Instr[5:3];
    assign imm6    = bus.Instr[5:0];
    assign imm     = {{(DW-6){imm6[5]}}, imm6};

    assign uses_rb = ~op[3];
    assign is_load = (op == 4'hC);
    assign we      = ~((op == 4'hD) | (op == 4'hF));
    assign use_imm = op[3] & (op != 4'hD);

    assign Raddr_a = ra;
    assign Raddr_b = rb;

    // WB data must win over the RF read because that write only lands at the coming edge.
    assign fwd_a = (Ex_we && !Ex_is_load && Ex_waddr == ra) ? Ex_result :
                   (Wb_we && Wb_waddr == ra)                ? Wb_data   : Rdata_a;
    assign fwd_b = (Ex_we && !Ex_is_load && Ex_waddr == rb) ? Ex_result :
                   (Wb_we && Wb_waddr == rb)                ? Wb_data   : Rdata_b;
    assign opnd_b = use_imm ? imm : fwd_b;

    assign hazard    = bus.In_valid & Ex_we & Ex_is_load &
                       ((Ex_waddr == ra) | (uses_rb & (Ex_waddr == rb)));
    assign bus.Stall = hazard & ~bus.Flush;

    // Flush, stall and empty slots all become bubbles. Data fields hold their last value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bus.Out_valid   <= 1'b0;
            bus.Out_op      <= '0;
            bus.Out_rd      <= '0;
            bus.Out_we      <= 1'b0;
            bus.Out_is_load <= 1'b0;
            bus.Out_a       <= '0;
            bus.Out_b       <= '0;
            Stall_count     <= 8'h00;
        end else begin
            if (bus.Stall && Stall_count != 8'hFF) begin
                Stall_count <= Stall_count + 8'd1;
            end
            if (bus.Flush || bus.Stall || !bus.In_valid) begin
                bus.Out_valid   <= 1'b0;
                bus.Out_we      <= 1'b0;
                bus.Out_is_load <= 1'b0;
            end else begin
                bus.Out_valid   <= 1'b1;
                bus.Out_op      <= op;
                bus.Out_rd      <= rd;
                bus.Out_we      <= we;
                bus.Out_is_load <= is_load;
                bus.Out_a       <= fwd_a;
                bus.Out_b       <= opnd_b;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage. A reference model queues the expected ID/EX bundle.
// That bundle is compared one cycle after each stimulus is applied.
module tb_operand_fetch_stage;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [2:0] Raddr_a, Raddr_b;
    logic [7:0] Rdata_a, Rdata_b;
    logic       Ex_we, Ex_is_load, Wb_we;
    logic [2:0] Ex_waddr, Wb_waddr;
    logic [7:0] Ex_result, Wb_data;
    logic [7:0] Stall_count;

    int vectors = 0;
    int miscompares = 0;
    int mCount = 0;

    typedef struct {
        logic       rst, in_valid, flush;
        logic [15:0] instr;
        logic [7:0] rdata_a, rdata_b;
        logic       ex_we, ex_load;
        logic [2:0] ex_waddr;
        logic [7:0] ex_result;
        logic       wb_we;
        logic [2:0] wb_waddr;
        logic [7:0] wb_data;
    } stim_t;

    typedef struct {
        logic       full;
        logic       valid, we, ld;
        logic [3:0] op;
        logic [2:0] rd;
        logic [7:0] a, b, count;
    } exp_t;

    exp_t sbQ[$];

    operand_fetch_stage_if #(.DW(8), .AW(3), .IW(16)) bus();

    operand_fetch_stage #(.DW(8), .AW(3), .IW(16)) dut (
        .Clk(Clk), .Rst(Rst), .bus(bus),
        .Raddr_a(Raddr_a), .Raddr_b(Raddr_b), .Rdata_a(Rdata_a), .Rdata_b(Rdata_b),
        .Ex_we(Ex_we), .Ex_waddr(Ex_waddr), .Ex_result(Ex_result), .Ex_is_load(Ex_is_load),
        .Wb_we(Wb_we), .Wb_waddr(Wb_waddr), .Wb_data(Wb_data), .Stall_count(Stall_count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, in_valid: 1'b0, flush: 1'b0, instr: 16'h0, rdata_a: 8'h0, rdata_b: 8'h0,
              ex_we: 1'b0, ex_load: 1'b0, ex_waddr: 3'd0, ex_result: 8'h0,
              wb_we: 1'b0, wb_waddr: 3'd0, wb_data: 8'h0};
        return s;
    endfunction

    function automatic logic [15:0] mkInstr(input logic [3:0] op, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [5:0] lo6);
        return {op, rd, ra, lo6};
    endfunction

    function automatic logic [7:0] modelFwd(input stim_t s, input logic [2:0] addr, input logic [7:0] rf);
        if (s.ex_we && !s.ex_load && s.ex_waddr == addr) return s.ex_result;
        if (s.wb_we && s.wb_waddr == addr) return s.wb_data;
        return rf;
    endfunction

    task automatic applyStimulus(input stim_t s);
        logic [3:0] op;
        logic [2:0] ra, rb;
        logic       usesRb, hz, expStall;
        exp_t       e, got;
        @(negedge Clk);
        Rst = s.rst; bus.In_valid = s.in_valid; bus.Flush = s.flush; bus.Instr = s.instr;
        Rdata_a = s.rdata_a; Rdata_b = s.rdata_b;
        Ex_we = s.ex_we; Ex_is_load = s.ex_load; Ex_waddr = s.ex_waddr; Ex_result = s.ex_result;
        Wb_we = s.wb_we; Wb_waddr = s.wb_waddr; Wb_data = s.wb_data;
        #1;
        op = s.instr[15:12]; ra = s.instr[8:6]; rb = s.instr[5:3];
        usesRb   = (op < 4'h8);
        hz       = s.in_valid && s.ex_we && s.ex_load && (s.ex_waddr == ra || (usesRb && s.ex_waddr == rb));
        expStall = hz && !s.flush;
        checkOutput("stall", {31'b0, bus.Stall}, {31'b0, expStall});
        checkOutput("raddr_a", {29'b0, Raddr_a}, {29'b0, ra});
        checkOutput("raddr_b", {29'b0, Raddr_b}, {29'b0, rb});
        e = '{full: 1'b0, valid: 1'b0, we: 1'b0, ld: 1'b0, op: 4'h0, rd: 3'd0, a: 8'h0, b: 8'h0, count: 8'h0};
        if (s.rst) begin
            mCount = 0;
            e.full = 1'b1;
        end else begin
            if (expStall && mCount < 255) mCount++;
            if (!(s.flush || expStall || !s.in_valid)) begin
                e.full  = 1'b1;
                e.valid = 1'b1;
                e.op    = op;
                e.rd    = s.instr[11:9];
                e.we    = !(op == 4'hD || op == 4'hF);
                e.ld    = (op == 4'hC);
                e.a     = modelFwd(s, ra, s.rdata_a);
                if (op >= 4'h8 && op != 4'hD) e.b = {{2{s.instr[5]}}, s.instr[5:0]};
                else e.b = modelFwd(s, rb, s.rdata_b);
            end
        end
        e.count = mCount[7:0];
        sbQ.push_back(e);
        @(posedge Clk);
        #1;
        if (sbQ.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sbQ.pop_front();
            checkOutput("out_valid", {31'b0, bus.Out_valid}, {31'b0, got.valid});
            checkOutput("out_we", {31'b0, bus.Out_we}, {31'b0, got.we});
            checkOutput("out_is_load", {31'b0, bus.Out_is_load}, {31'b0, got.ld});
            checkOutput("stall_count", {24'b0, Stall_count}, {24'b0, got.count});
            if (got.full) begin
                checkOutput("out_op", {28'b0, bus.Out_op}, {28'b0, got.op});
                checkOutput("out_rd", {29'b0, bus.Out_rd}, {29'b0, got.rd});
                checkOutput("out_a", {24'b0, bus.Out_a}, {24'b0, got.a});
                checkOutput("out_b", {24'b0, bus.Out_b}, {24'b0, got.b});
            end
        end
    endtask

    initial begin
        stim_t s;
        $display("[TB] starting operand_fetch_stage bench");

        // Reset with a valid instruction present must still yield an all-zero bundle.
        s = idle();
        s.rst = 1'b1; s.in_valid = 1'b1; s.instr = mkInstr(4'h0, 3'd3, 3'd1, 6'o20);
        applyStimulus(s);
        applyStimulus(s);

        // ADD r3 = r1 + r2 straight from the RF.
        s = idle();
        s.in_valid = 1'b1; s.instr = mkInstr(4'h0, 3'd3, 3'd1, 6'o20);
        s.rdata_a = 8'h05; s.rdata_b = 8'h07;
        applyStimulus(s);
        checkOutput("plan_add_a", {24'b0, bus.Out_a}, 32'h05);
        checkOutput("plan_add_b", {24'b0, bus.Out_b}, 32'h07);

        // EX result must take priority over the WB write to the same register.
        s.ex_we = 1'b1; s.ex_waddr = 3'd1; s.ex_result = 8'hAA;
        s.wb_we = 1'b1; s.wb_waddr = 3'd1; s.wb_data = 8'h55;
        applyStimulus(s);
        checkOutput("plan_ex_fwd", {24'b0, bus.Out_a}, 32'hAA);
        s.ex_we = 1'b0;
        applyStimulus(s);
        checkOutput("plan_wb_fwd", {24'b0, bus.Out_a}, 32'h55);

        // Load-use on rb: one bubble, then WB forwarding supplies the load data.
        s = idle();
        s.in_valid = 1'b1; s.instr = mkInstr(4'h1, 3'd4, 3'd0, 6'o20);
        s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_waddr = 3'd2;
        applyStimulus(s);
        s.ex_we = 1'b0; s.ex_load = 1'b0;
        s.wb_we = 1'b1; s.wb_waddr = 3'd2; s.wb_data = 8'h3C;
        applyStimulus(s);
        checkOutput("plan_lu_b", {24'b0, bus.Out_b}, 32'h3C);
        checkOutput("plan_lu_cnt", {24'b0, Stall_count}, 32'h01);

        // Immediate form ignores rb, so a pending load into rb causes no stall.
        s = idle();
        s.in_valid = 1'b1; s.instr = mkInstr(4'h8, 3'd4, 3'd1, 6'b111110);
        s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_waddr = 3'd7;
        applyStimulus(s);
        checkOutput("plan_imm_b", {24'b0, bus.Out_b}, 32'hFE);

        // A store reads rb rather than the immediate and produces no register write.
        s = idle();
        s.in_valid = 1'b1; s.instr = mkInstr(4'hD, 3'd0, 3'd5, 6'o61);
        s.rdata_a = 8'h11; s.rdata_b = 8'h22;
        applyStimulus(s);
        s.in_valid = 1'b0;
        applyStimulus(s);

        // Flush on top of a hazard suppresses both the stall and the count update.
        s = idle();
        s.in_valid = 1'b1; s.flush = 1'b1; s.instr = mkInstr(4'h0, 3'd1, 3'd2, 6'o30);
        s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_waddr = 3'd2;
        applyStimulus(s);

        // Mixed traffic drawn at random.
        for (int i = 0; i < 40; i++) begin
            s = idle();
            s.in_valid = ($urandom_range(0, 3) != 0);
            s.flush = ($urandom_range(0, 7) == 0);
            s.instr = 16'($urandom);
            s.rdata_a = 8'($urandom); s.rdata_b = 8'($urandom);
            s.ex_we = 1'($urandom); s.ex_load = 1'($urandom);
            s.ex_waddr = 3'($urandom); s.ex_result = 8'($urandom);
            s.wb_we = 1'($urandom); s.wb_waddr = 3'($urandom); s.wb_data = 8'($urandom);
            applyStimulus(s);
        end

        // A hazard held for 300 cycles drives the counter into saturation.
        s = idle();
        s.in_valid = 1'b1; s.instr = mkInstr(4'h0, 3'd1, 3'd2, 6'o30);
        s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_waddr = 3'd2;
        for (int i = 0; i < 300; i++) applyStimulus(s);
        checkOutput("plan_sat", {24'b0, Stall_count}, 32'hFF);
        s.rst = 1'b1;
        applyStimulus(s);
        checkOutput("plan_sat_rst", {24'b0, Stall_count}, 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
